remote_comm: RTL and testbench



---
 rtl/remote_comm_if.sv | 10 +
 rtl/remote_comm.sv | 122 ++++++++++++
 tb/tb_remote_comm.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/remote_comm_if.sv
// remote_comm_if: command/response handshake between the test sequencer and remote_comm.
interface remote_comm_if;
   logic [15:0] cmd;
   logic        send_cmd;
   logic        cmd_sent;
   logic        resp_rdy;
   logic [7:0]  resp;
   modport master (output cmd, send_cmd, input cmd_sent, resp_rdy, resp);
   modport slave (input cmd, send_cmd, output cmd_sent, resp_rdy, resp);
endinterface

// File: rtl/remote_comm.sv
// remote_comm: UART 8N1 host link, 16-bit command out as two frames, 8-bit response in.
// Define REMOTE_COMM_RX_SYNC_EN for a two-flop RX synchronizer (default: single flop).
module remote_comm #(
   parameter int BAUD_DIV = 2604
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         RX,
   output logic         TX,
   remote_comm_if.slave bus
);
   localparam int CW = $clog2(BAUD_DIV + 1);
   typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_e;
   typedef enum logic {RX_IDLE, RX_RECV} rx_state_e;
   tx_state_e     tx_state_q, tx_state_d;
   logic [15:0]   cmd_q, cmd_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]    tx_bit_q, tx_bit_d;
   logic          tx_q, tx_d, cmd_sent_q, cmd_sent_d;
   logic          accept, tick, last;
   logic [7:0]    tx_byte;
   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [3:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_data_q, rx_data_d, resp_q, resp_d;
   logic          resp_rdy_q, resp_rdy_d, rx_prev_q, rx_s;
   logic          start_det, sample, set_rdy;
`ifdef REMOTE_COMM_RX_SYNC_EN
   logic [1:0] rx_sync_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) rx_sync_q <= 2'b11;
      else rx_sync_q <= {rx_sync_q[0], RX};
   assign rx_s = rx_sync_q[1];
`else
   logic rx_sync_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) rx_sync_q <= 1'b1;
      else rx_sync_q <= RX;
   assign rx_s = rx_sync_q;
`endif
   always_comb begin
      accept = tx_state_q == TX_IDLE && bus.send_cmd;
      tick = tx_cnt_q == CW'(BAUD_DIV - 1);
      last = tx_bit_q == 4'd9;
      tx_byte = tx_state_q == TX_HIGH ? cmd_q[15:8] : cmd_q[7:0];
      tx_state_d = tx_state_q;
      cmd_d = accept ? bus.cmd : cmd_q;
      tx_cnt_d = tx_cnt_q + 1'b1;
      tx_bit_d = tx_bit_q;
      cmd_sent_d = accept ? 1'b0 : cmd_sent_q;
      tx_d = tx_state_q == TX_IDLE || last ? 1'b1 : tx_bit_q == 4'd0 ? 1'b0 : tx_byte[3'(tx_bit_q - 4'd1)];
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            if (accept) tx_state_d = TX_HIGH;
         end
         TX_HIGH: if (tick) begin
            tx_cnt_d = '0;
            tx_bit_d = last ? 4'd0 : tx_bit_q + 4'd1;
            if (last) tx_state_d = TX_LOW;
         end
         // low stop bit is counted one clock longer so IDLE returns on the cmd_sent edge
         default: if (last && tx_cnt_q == CW'(BAUD_DIV)) begin
            tx_state_d = TX_IDLE;
            tx_cnt_d = '0;
            tx_bit_d = '0;
            cmd_sent_d = 1'b1;
         end else if (tick && !last) begin
            tx_cnt_d = '0;
            tx_bit_d = tx_bit_q + 4'd1;
         end
      endcase
   end
   always_comb begin
      start_det = rx_state_q == RX_IDLE && rx_prev_q && !rx_s;
      sample = rx_state_q == RX_RECV &&
               rx_cnt_q == (rx_bit_q == 4'd0 ? CW'(BAUD_DIV / 2 - 1) : CW'(BAUD_DIV - 1));
      set_rdy = sample && rx_bit_q == 4'd9 && rx_s;
      rx_state_d = start_det ? RX_RECV : sample && rx_bit_q == 4'd9 ? RX_IDLE : rx_state_q;
      rx_cnt_d = rx_state_q == RX_IDLE || sample ? '0 : rx_cnt_q + 1'b1;
      rx_bit_d = rx_state_q == RX_IDLE || (sample && rx_bit_q == 4'd9) ? 4'd0 :
                 sample ? rx_bit_q + 4'd1 : rx_bit_q;
      rx_data_d = sample && rx_bit_q != 4'd0 && rx_bit_q != 4'd9 ? {rx_s, rx_data_q[7:1]} : rx_data_q;
      resp_d = set_rdy ? rx_data_q : resp_q;
      resp_rdy_d = set_rdy ? 1'b1 : start_det || accept ? 1'b0 : resp_rdy_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tx_state_q <= TX_IDLE;
         cmd_q      <= '0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_q       <= 1'b1;
         cmd_sent_q <= 1'b0;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_data_q  <= '0;
         resp_q     <= '0;
         resp_rdy_q <= 1'b0;
         rx_prev_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         cmd_q      <= cmd_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_q       <= tx_d;
         cmd_sent_q <= cmd_sent_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_data_q  <= rx_data_d;
         resp_q     <= resp_d;
         resp_rdy_q <= resp_rdy_d;
         rx_prev_q  <= rx_s;
      end
   assign TX = tx_q;
   assign bus.cmd_sent = cmd_sent_q;
   assign bus.resp_rdy = resp_rdy_q;
   assign bus.resp = resp_q;
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed bench with TX/RX scoreboards for remote_comm.
module tb_remote_comm;
   localparam int B = 16;
`ifdef REMOTE_COMM_RX_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 1;
`endif
   localparam int L = S + B / 2 + 9 * B + 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic RX = 1'b1;
   logic TX;
   int tests = 0;
   int fails = 0;
   int sent_rises = 0;
   logic [7:0] tx_exp[$];
   logic [7:0] resp_exp[$];
   logic [7:0] last_resp = 8'h00;
   logic exp_rdy = 1'b0;
   logic ab;
   remote_comm_if bus();
   remote_comm #(.BAUD_DIV(B)) dut (.clk(clk), .rst(rst), .RX(RX), .TX(TX), .bus(bus));
   initial forever #5 clk = ~clk;
   always @(posedge bus.cmd_sent) sent_rises++;
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic wait_tx(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rst) ab = 1'b1;
      end
   endtask
   // TX monitor: decodes frames mid-bit and pops the expected byte; frames hit by reset are dropped
   initial begin
      logic [7:0] b;
      logic st, sp;
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (TX === 1'b0) begin
            ab = 1'b0;
            wait_tx(B / 2);
            st = TX;
            for (int k = 0; k < 8; k++) begin
               wait_tx(B);
               b[k] = TX;
            end
            wait_tx(B);
            sp = TX;
            if (!ab) begin
               if (tx_exp.size() != 0) e = {8'h00, tx_exp.pop_front()};
               else e = 16'hFFFF;
               chk("tx_start_bit", {15'd0, st}, 16'd0);
               chk("tx_stop_bit", {15'd0, sp}, 16'd1);
               chk("tx_byte", {8'h00, b}, e);
            end
         end
      end
   end
   task automatic send(input logic [15:0] c, input int pulse_at);
      int s0;
      s0 = sent_rises;
      @(negedge clk);
      bus.cmd = c;
      bus.send_cmd = 1'b1;
      tx_exp.push_back(c[15:8]);
      tx_exp.push_back(c[7:0]);
      @(negedge clk);
      bus.send_cmd = 1'b0;
      bus.cmd = ~c;
      exp_rdy = 1'b0;
      chk("tx_idle_at_accept", {15'd0, TX}, 16'd1);
      chk("sent_cleared", {15'd0, bus.cmd_sent}, 16'd0);
      chk("rdy_clr_on_send", {15'd0, bus.resp_rdy}, 16'd0);
      for (int i = 1; i <= 20 * B; i++) begin
         if (i == pulse_at) begin
            bus.cmd = 16'h2000;
            bus.send_cmd = 1'b1;
         end
         @(negedge clk);
         bus.send_cmd = 1'b0;
         if (i == 1) chk("tx_hi_start", {15'd0, TX}, 16'd0);
         if (i == 10 * B) chk("tx_hi_stop", {15'd0, TX}, 16'd1);
         if (i == 10 * B + 1) chk("tx_lo_start", {15'd0, TX}, 16'd0);
         if (i == 20 * B) chk("sent_not_early", {15'd0, bus.cmd_sent}, 16'd0);
      end
      @(negedge clk);
      chk("sent_on_time", {15'd0, bus.cmd_sent}, 16'd1);
      chk("tx_idle_after", {15'd0, TX}, 16'd1);
      repeat (2 * B) @(negedge clk);
      chk("sent_held", {15'd0, bus.cmd_sent}, 16'd1);
      chk("sent_once", 16'(sent_rises - s0), 16'd1);
   endtask
   task automatic rx_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      if (stop) resp_exp.push_back(b);
      @(posedge clk);
      #1 RX = 1'b0;
      for (int j = 1; j <= 10 * B + 4; j++) begin
         @(posedge clk);
         #1 RX = j < 10 * B ? f[j / B] : 1'b1;
         if (j == S) chk("rdy_before_start", {15'd0, bus.resp_rdy}, {15'd0, exp_rdy});
         if (j == S + 1) chk("rdy_clr_on_start", {15'd0, bus.resp_rdy}, 16'd0);
         if (j == L - 1) chk("rdy_not_early", {15'd0, bus.resp_rdy}, 16'd0);
         if (j == L) begin
            chk("rdy_at_latency", {15'd0, bus.resp_rdy}, {15'd0, stop});
            if (stop) last_resp = resp_exp.pop_front();
            chk("resp_value", {8'h00, bus.resp}, {8'h00, last_resp});
            exp_rdy = stop;
         end
      end
   endtask
   initial begin
      int s0;
      bus.cmd = 16'h0000;
      bus.send_cmd = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_tx", {15'd0, TX}, 16'd1);
      chk("rst_sent", {15'd0, bus.cmd_sent}, 16'd0);
      chk("rst_rdy", {15'd0, bus.resp_rdy}, 16'd0);
      chk("rst_resp", {8'h00, bus.resp}, 16'h0000);
      rst = 1'b0;
      send(16'h4001, 0);
      rx_frame(8'hA5, 1'b1);
      rx_frame(8'h5A, 1'b0);
      rx_frame(8'h5A, 1'b1);
      send(16'h4001, 5 * B);
      // back-to-back: send_cmd held across the end of the first transfer
      s0 = sent_rises;
      @(negedge clk);
      bus.cmd = 16'h1234;
      bus.send_cmd = 1'b1;
      tx_exp.push_back(8'h12);
      tx_exp.push_back(8'h34);
      tx_exp.push_back(8'hBE);
      tx_exp.push_back(8'hEF);
      @(negedge clk);
      bus.cmd = 16'hBEEF;
      repeat (20 * B + 1) @(negedge clk);
      chk("b2b_sent_first", {15'd0, bus.cmd_sent}, 16'd1);
      @(negedge clk);
      bus.send_cmd = 1'b0;
      chk("b2b_sent_cleared", {15'd0, bus.cmd_sent}, 16'd0);
      chk("b2b_gap_idle", {15'd0, TX}, 16'd1);
      @(negedge clk);
      chk("b2b_second_start", {15'd0, TX}, 16'd0);
      repeat (20 * B) @(negedge clk);
      chk("b2b_sent_second", {15'd0, bus.cmd_sent}, 16'd1);
      chk("b2b_rises", 16'(sent_rises - s0), 16'd2);
      repeat (2 * B) @(negedge clk);
      // reset in the middle of the low byte
      s0 = sent_rises;
      @(negedge clk);
      bus.cmd = 16'h0610;
      bus.send_cmd = 1'b1;
      tx_exp.push_back(8'h06);
      @(negedge clk);
      bus.send_cmd = 1'b0;
      repeat (12 * B) @(negedge clk);
      chk("abort_tx_low", {15'd0, TX}, 16'd0);
      rst = 1'b1;
      #1;
      chk("abort_tx_async", {15'd0, TX}, 16'd1);
      chk("abort_sent", {15'd0, bus.cmd_sent}, 16'd0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      exp_rdy = 1'b0;
      repeat (20 * B) @(negedge clk);
      chk("abort_no_sent", 16'(sent_rises - s0), 16'd0);
      chk("abort_tx_idle", {15'd0, TX}, 16'd1);
      send(16'h0610, 0);
      repeat (2 * B) @(negedge clk);
      chk("tx_queue_empty", 16'(tx_exp.size()), 16'd0);
      chk("resp_queue_empty", 16'(resp_exp.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
